// File: rtl/tdc_pkg.sv
// tdc_pkg: shared state encoding and default widths for the TDC self-test sequencer.
package tdc_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_ARM,
    S_WAIT_START,
    S_WAIT_STOP,
    S_REPORT
  } state_t;
  localparam int CNT_W_DEF = 16;
  localparam int ITER_W_DEF = 8;
  localparam logic [CNT_W_DEF-1:0] TIMEOUT_CODE = '1;
endpackage

// File: rtl/tdc_test_sequencer_edge_det.sv
// edge_det: registered rising-edge detector; edge = current input and not previous sample.
module edge_det (
  input  logic clk,
  input  logic res,
  input  logic i_d,
  output logic o_rise
);
  logic r_prev;
  always_ff @(posedge clk)
    if (res) r_prev <= 1'b0;
    else r_prev <= i_d;
  assign o_rise = i_d & ~r_prev;
endmodule

// File: rtl/tdc_test_sequencer.sv
// tdc_test_sequencer: sweeps enabled TDC addresses, arms testcounter and times start->stop intervals.
module tdc_test_sequencer
  import tdc_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int ITER_W  = ITER_W_DEF,
  parameter int TIMEOUT = 8191
) (
  input  logic              clk,
  input  logic              res,
  input  logic              cmd_go,
  input  logic [7:0]        addr_mask,
  input  logic [ITER_W-1:0] cmd_iter,
  input  logic              teststart,
  input  logic              teststop,
  output logic              res_test,
  output logic [2:0]        fpga_addr,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2:0]        res_addr,
  output logic [CNT_W-1:0]  res_delta,
  output logic              res_timeout,
  output logic              busy,
  output logic              done
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t            r_state;
  logic [7:0]        r_mask;
  logic [ITER_W-1:0] r_iter, r_iter_cnt;
  logic [3:0]        r_ptr;
  logic [CNT_W-1:0]  r_cnt, r_res_delta;
  logic [TW-1:0]     r_tcnt;
  logic [2:0]        r_fpga_addr, r_res_addr;
  logic              r_res_test, r_res_valid, r_res_timeout, r_busy, r_done;
  logic              w_start_rise, w_stop_rise, w_ws, w_wstop, w_tmo, w_zero, w_stop, w_to;
  logic [CNT_W-1:0]  w_cnt_inc;

  edge_det u_start (.clk(clk), .res(res), .i_d(teststart), .o_rise(w_start_rise));
  edge_det u_stop  (.clk(clk), .res(res), .i_d(teststop),  .o_rise(w_stop_rise));

  assign w_ws      = r_state == S_WAIT_START;
  assign w_wstop   = r_state == S_WAIT_STOP;
  assign w_tmo     = r_tcnt >= TW'(TIMEOUT - 1);
  assign w_cnt_inc = &r_cnt ? r_cnt : r_cnt + CNT_W'(1);
  // Edges win over a coincident timeout; a lone stop edge in WAIT_START is ignored.
  assign w_zero    = w_ws & w_start_rise & w_stop_rise;
  assign w_stop    = w_wstop & w_stop_rise;
  assign w_to      = ((w_ws & ~w_start_rise) | (w_wstop & ~w_stop_rise)) & w_tmo;

  always_ff @(posedge clk) begin
    if (res) begin
      r_state       <= S_IDLE;
      r_mask        <= '0;
      r_iter        <= '0;
      r_iter_cnt    <= '0;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_tcnt        <= '0;
      r_fpga_addr   <= '0;
      r_res_addr    <= '0;
      r_res_delta   <= '0;
      r_res_test    <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_timeout <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_res_test <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE:
          if (cmd_go) begin
            r_mask  <= addr_mask;
            r_iter  <= cmd_iter;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_PICK;
          end
        S_PICK:
          if (r_ptr[3] || r_iter == '0) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_mask[r_ptr[2:0]]) begin
            r_fpga_addr <= r_ptr[2:0];
            r_iter_cnt  <= r_iter;
            r_res_test  <= 1'b1;
            r_state     <= S_ARM;
          end else r_ptr <= r_ptr + 4'd1;
        S_ARM: begin
          r_cnt   <= '0;
          r_tcnt  <= '0;
          r_state <= S_WAIT_START;
        end
        S_WAIT_START: begin
          r_tcnt <= r_tcnt + TW'(1);
          if (w_start_rise && !w_stop_rise) begin
            r_cnt   <= CNT_W'(1);
            r_state <= S_WAIT_STOP;
          end
        end
        S_WAIT_STOP: begin
          r_tcnt <= r_tcnt + TW'(1);
          r_cnt  <= w_cnt_inc;
        end
        S_REPORT:
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (r_iter_cnt != ITER_W'(1)) begin
              r_iter_cnt <= r_iter_cnt - ITER_W'(1);
              r_res_test <= 1'b1;
              r_state    <= S_ARM;
            end else begin
              r_ptr   <= {1'b0, r_fpga_addr} + 4'd1;
              r_state <= S_PICK;
            end
          end
        default: r_state <= S_IDLE;
      endcase
      if (w_zero || w_stop || w_to) begin
        r_res_valid   <= 1'b1;
        r_res_addr    <= r_fpga_addr;
        r_res_delta   <= w_to ? '1 : (w_zero ? '0 : r_cnt);
        r_res_timeout <= w_to;
        r_state       <= S_REPORT;
      end
    end
  end

  assign res_test    = r_res_test;
  assign fpga_addr   = r_fpga_addr;
  assign res_valid   = r_res_valid;
  assign res_addr    = r_res_addr;
  assign res_delta   = r_res_delta;
  assign res_timeout = r_res_timeout;
  assign busy        = r_busy;
  assign done        = r_done;
endmodule

// File: tb/tb_tdc_test_sequencer.sv
// tb_tdc_test_sequencer: directed self-checking bench for the TDC test sequencer.
module tb_tdc_test_sequencer;
  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        cmd_go = 1'b0;
  logic [7:0]  addr_mask = '0;
  logic [7:0]  cmd_iter = '0;
  logic        teststart = 1'b0;
  logic        teststop = 1'b0;
  logic        res_ready = 1'b1;
  logic        res_test, res_valid, res_timeout, busy, done;
  logic [2:0]  fpga_addr, res_addr;
  logic [15:0] res_delta;
  int n_vec = 0;
  int n_err = 0;
  int n_pulse = 0;

  tdc_test_sequencer #(.CNT_W(16), .ITER_W(8), .TIMEOUT(100)) dut (
    .clk(clk), .res(res), .cmd_go(cmd_go), .addr_mask(addr_mask), .cmd_iter(cmd_iter),
    .teststart(teststart), .teststop(teststop), .res_test(res_test), .fpga_addr(fpga_addr),
    .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr), .res_delta(res_delta),
    .res_timeout(res_timeout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (res_test) n_pulse++;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // which: 0 = res_test, 1 = res_valid, 2 = done; returns steps taken (max+1 when expired)
  task automatic wait_for(input int which, input int maxc, output int n);
    n = maxc + 1;
    for (int i = 1; i <= maxc; i++) begin
      step;
      if ((which == 0 && res_test) || (which == 1 && res_valid) || (which == 2 && done)) begin
        n = i;
        return;
      end
    end
  endtask

  // Called with the DUT in ARM (res_test visible); ends with the result on the outputs.
  task automatic measure(input string tag, input int gap, input bit pre_stop,
                         input logic [2:0] ea, input logic [15:0] ed);
    step;
    chk({tag, "_arm_1cyc"}, res_test, 1'b0);
    if (pre_stop) begin
      teststop = 1'b1;
      step;
      teststop = 1'b0;
      step;
    end
    teststart = 1'b1;
    if (gap == 0) teststop = 1'b1;
    step;
    teststart = 1'b0;
    teststop  = 1'b0;
    if (gap > 0) begin
      repeat (gap - 1) step;
      teststop = 1'b1;
      step;
      teststop = 1'b0;
    end
    chk({tag, "_valid"}, res_valid, 1'b1);
    chk({tag, "_addr"}, res_addr, ea);
    chk({tag, "_delta"}, res_delta, ed);
    chk({tag, "_tmo"}, res_timeout, 1'b0);
  endtask

  initial begin
    int n, p0;
    bit stable;
    step;
    step;
    chk("reset_outs", {res_test, fpga_addr, res_valid, res_addr, res_delta, res_timeout, busy, done}, 0);
    res = 1'b0;
    step;

    // single address, single run, 10-cycle interval
    addr_mask = 8'h01; cmd_iter = 8'd1; cmd_go = 1'b1; p0 = n_pulse;
    step;
    cmd_go = 1'b0;
    chk("t1_busy", busy, 1'b1);
    wait_for(0, 10, n);
    chk("t1_arm_lat", n, 1);
    chk("t1_fpga_addr", fpga_addr, 3'd0);
    measure("t1", 10, 1'b0, 3'd0, 16'd10);
    wait_for(2, 20, n);
    chk("t1_done_lat", n, 9);
    chk("t1_busy_at_done", busy, 1'b0);
    chk("t1_pulses", n_pulse - p0, 1);
    step;
    chk("t1_done_1cyc", done, 1'b0);

    // two addresses, two runs each; go held and mask changed mid-sweep are ignored
    addr_mask = 8'h82; cmd_iter = 8'd2; cmd_go = 1'b1; p0 = n_pulse;
    step;
    addr_mask = 8'h00; cmd_iter = 8'd0;
    wait_for(0, 10, n);
    cmd_go = 1'b0;
    chk("t2_first_arm", n, 2);
    chk("t2_addr1", fpga_addr, 3'd1);
    measure("t2a", 3, 1'b0, 3'd1, 16'd3);
    wait_for(0, 10, n);
    chk("t2_rearm_lat", n, 1);
    measure("t2b", 5, 1'b0, 3'd1, 16'd5);
    wait_for(0, 20, n);
    chk("t2_pick7_lat", n, 7);
    chk("t2_addr7", fpga_addr, 3'd7);
    measure("t2c", 1, 1'b0, 3'd7, 16'd1);
    wait_for(0, 10, n);
    chk("t2_rearm7", n, 1);
    measure("t2d_stop_only", 2, 1'b1, 3'd7, 16'd2);
    wait_for(2, 20, n);
    chk("t2_done_lat", n, 2);
    chk("t2_pulses", n_pulse - p0, 4);

    // timeout, back-pressure, then sweep continues with a same-cycle start/stop
    addr_mask = 8'h01; cmd_iter = 8'd2; res_ready = 1'b0; cmd_go = 1'b1; p0 = n_pulse;
    step;
    cmd_go = 1'b0;
    wait_for(0, 10, n);
    chk("t3_arm_lat", n, 1);
    wait_for(1, 200, n);
    chk("t3_tmo_lat", n, 101);
    chk("t3_tmo_flag", res_timeout, 1'b1);
    chk("t3_tmo_delta", res_delta, 16'hFFFF);
    chk("t3_tmo_addr", res_addr, 3'd0);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step;
      if (!(res_valid && res_timeout && res_delta == 16'hFFFF && res_addr == 3'd0 && !res_test))
        stable = 1'b0;
    end
    chk("t3_hold_stable", stable, 1'b1);
    chk("t3_hold_pulses", n_pulse - p0, 1);
    res_ready = 1'b1;
    wait_for(0, 10, n);
    chk("t3_accept_rearm", n, 1);
    measure("t3_zero", 0, 1'b0, 3'd0, 16'd0);
    wait_for(2, 20, n);
    chk("t3_done_lat", n, 9);

    // reset in WAIT_STOP
    addr_mask = 8'h04; cmd_iter = 8'd1; cmd_go = 1'b1;
    step;
    cmd_go = 1'b0;
    wait_for(0, 10, n);
    chk("t4_arm_lat", n, 3);
    chk("t4_addr2", fpga_addr, 3'd2);
    step;
    teststart = 1'b1;
    step;
    teststart = 1'b0;
    step;
    step;
    res = 1'b1;
    step;
    res = 1'b0;
    chk("t4_reset_outs", {res_test, fpga_addr, res_valid, res_addr, res_delta, res_timeout, busy, done}, 0);
    teststop = 1'b1;
    step;
    teststop = 1'b0;
    step;
    chk("t4_no_result", {res_valid, busy}, 0);

    // empty mask and zero iterations
    addr_mask = 8'h00; cmd_iter = 8'd3; cmd_go = 1'b1; p0 = n_pulse;
    wait_for(2, 20, n);
    cmd_go = 1'b0;
    chk("t5_mask0_done", n, 10);
    addr_mask = 8'hFF; cmd_iter = 8'd0; cmd_go = 1'b1;
    step;
    cmd_go = 1'b0;
    wait_for(2, 20, n);
    chk("t5_iter0_done", n, 1);
    chk("t5_no_pulses", n_pulse - p0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
